// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider.
//   div_state_t : controller state encoding
//   DIV_DW/VW   : default dividend/quotient and divisor/remainder widths
//   cond_neg    : conditional two's-complement negate, used both to take
//                 operand magnitudes and to re-apply result signs.
package div_pkg;

  localparam int DIV_DW = 32;
  localparam int DIV_VW = 16;

  // Working width of cond_neg; callers zero-extend into it and keep the
  // low bits.
  localparam int NEG_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_t;

  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v,
                                                input logic             neg);
    return neg ? (~v + NEG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle of the sequential divider.
//   master : drives start/dividend/divisor, observes status and results
//   slave  : the divider side
interface seq_divider_if #(
  parameter int DW = 32,
  parameter int VW = 16
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed divider, restoring algorithm, one quotient bit per clock.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if slave (start/dividend/divisor in; busy, done,
//           quotient, remainder, div_by_zero, overflow out)
//
// state | meaning
// IDLE  | waiting for start; results and flags hold
// PREP  | divide-by-zero trap or load operand magnitudes
// ITER  | DW shift/subtract steps
// FIX   | apply signs, raise done
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(DW);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] qreg_q, qreg_d;
  logic [VW:0]   part_q, part_d;
  logic [VW-1:0] dmag_q, dmag_d;
  logic          sgn_q_q, sgn_q_d;
  logic          sgn_r_q, sgn_r_d;
  logic          ovf_cand_q, ovf_cand_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0]       dvd_abs, quo_sgn;
  logic [VW-1:0]       dvs_abs, rem_sgn;
  logic [NEG_W-DW-1:0] dvd_spare_unused, quo_spare_unused;
  logic [NEG_W-VW-1:0] dvs_spare_unused, rem_spare_unused;

  // Magnitude of -2^(DW-1) wraps back to the unsigned pattern 2^(DW-1),
  // which the unsigned loop handles correctly.
  assign {dvd_spare_unused, dvd_abs} = cond_neg(NEG_W'(dvd_q), sgn_r_q);
  assign {dvs_spare_unused, dvs_abs} = cond_neg(NEG_W'(dvs_q), dvs_q[VW-1]);
  assign {quo_spare_unused, quo_sgn} = cond_neg(NEG_W'(qreg_q), sgn_q_q);
  assign {rem_spare_unused, rem_sgn} = cond_neg(NEG_W'(part_q[VW-1:0]), sgn_r_q);

  logic [VW:0]   p_sh;
  logic [DW-1:0] q_sh;
  logic [VW+1:0] diff;
  logic          fits;

  // A bit shifted out of part_q[VW] means the value already exceeds any
  // VW-bit magnitude, so the subtract always succeeds.
  assign p_sh = {part_q[VW-1:0], qreg_q[DW-1]};
  assign q_sh = {qreg_q[DW-2:0], 1'b0};
  assign diff = {1'b0, p_sh} - {2'b00, dmag_q};
  assign fits = part_q[VW] | ~diff[VW+1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    qreg_d     = qreg_q;
    part_d     = part_q;
    dmag_d     = dmag_q;
    sgn_q_d    = sgn_q_q;
    sgn_r_d    = sgn_r_q;
    ovf_cand_d = ovf_cand_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d      = bus.dividend;
          dvs_d      = bus.divisor;
          sgn_q_d    = bus.dividend[DW-1] ^ bus.divisor[VW-1];
          sgn_r_d    = bus.dividend[DW-1];
          ovf_cand_d = (bus.dividend == {1'b1, {(DW-1){1'b0}}}) &&
                       (bus.divisor == {VW{1'b1}});
          busy_d     = 1'b1;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          state_d    = PREP;
        end
      end
      PREP: begin
        if (dvs_q == '0) begin
          quot_d  = '0;
          rem_d   = '0;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          qreg_d  = dvd_abs;
          dmag_d  = dvs_abs;
          part_d  = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        part_d = fits ? diff[VW:0] : p_sh;
        qreg_d = {q_sh[DW-1:1], fits};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = quo_sgn;
        rem_d   = rem_sgn;
        ovf_d   = ovf_cand_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      qreg_q     <= '0;
      part_q     <= '0;
      dmag_q     <= '0;
      sgn_q_q    <= 1'b0;
      sgn_r_q    <= 1'b0;
      ovf_cand_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      qreg_q     <= qreg_d;
      part_q     <= part_d;
      dmag_q     <= dmag_d;
      sgn_q_q    <= sgn_q_d;
      sgn_r_q    <= sgn_r_d;
      ovf_cand_q <= ovf_cand_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: expected results are pushed to a
// scoreboard when an operation is started and popped when done rises.
module tb_seq_divider;

  typedef struct packed {
    logic [31:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  seq_divider_if #(.DW(32), .VW(16)) bus ();

  seq_divider #(.DW(32), .VW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t   e;
    longint la, lb, lq, lr;
    e = '0;
    if (b == 16'd0) begin
      e.dbz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 16'hFFFF) begin
      e.q   = 32'h8000_0000;
      e.ovf = 1'b1;
    end else begin
      la  = longint'(signed'(a));
      lb  = longint'(signed'(b));
      lq  = la / lb;
      lr  = la % lb;
      e.q = lq[31:0];
      e.r = lr[15:0];
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; the next posedge accepts the operation.
  task automatic do_start(input logic [31:0] a, input logic [15:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    acc_cyc      = cyc;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
  endtask

  // Returns on the negedge where done is high; latency is posedges after
  // the accepting edge.
  task automatic wait_done(input string tag, input int exp_lat);
    exp_t e;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && (cyc - acc_cyc) < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(exp_lat));
    check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    check({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_quot"}, 64'(bus.quotient), 64'(e.q));
    check({tag, "_rem"}, 64'(bus.remainder), 64'(e.r));
    check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(e.ovf));
  endtask

  task automatic check_pulse(input string tag, input logic [31:0] q, input logic [15:0] r);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
    check({tag, "_quot_hold"}, 64'(bus.quotient), 64'(q));
    check({tag, "_rem_hold"}, 64'(bus.remainder), 64'(r));
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] rb;
    int          seen;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_quot", 64'(bus.quotient), 64'd0);
    check("rst_rem", 64'(bus.remainder), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_start(32'd1200, 16'd12);
    wait_done("d1200_12", 34);
    check("d1200_12_busy_cycles", 64'(busy_cnt), 64'd34);
    check_pulse("d1200_12", 32'd100, 16'd0);

    do_start(-32'sd7, 16'sd2);
    wait_done("dm7_2", 34);
    do_start(32'sd7, -16'sd2);
    wait_done("d7_m2", 34);
    do_start(-32'sd7, -16'sd2);
    wait_done("dm7_m2", 34);

    // Zero divisor finishes one edge after the accepting edge.
    do_start(32'd2550, 16'd0);
    wait_done("dbz", 1);
    check("dbz_busy_cycles", 64'(busy_cnt), 64'd1);
    check_pulse("dbz", 32'd0, 16'd0);

    do_start(32'h8000_0000, 16'hFFFF);
    wait_done("ovf", 34);
    do_start(32'h8000_0000, 16'd1);
    wait_done("min_by_1", 34);
    do_start(32'd100000, 16'h8000);
    wait_done("div_min", 34);

    do_start(32'd360, 16'd4);
    repeat (9) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 16'd12;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_busy", 34);
    do_start(32'd85, 16'd30);
    wait_done("back2back", 34);
    check_pulse("back2back", 32'd2, 16'd25);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = 16'($urandom);
      if (rb == 16'd0) rb = 16'd3;
      do_start(ra, rb);
      wait_done($sformatf("rand%0d", i), 34);
    end

    do_start(32'd1200, 16'd12);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_quot", 64'(bus.quotient), 64'd0);
    check("abort_rem", 64'(bus.remainder), 64'd0);
    check("abort_dbz", 64'(bus.div_by_zero), 64'd0);
    check("abort_ovf", 64'(bus.overflow), 64'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_idle_busy", 64'(bus.busy), 64'd0);

    do_start(32'd90, 16'd4);
    wait_done("after_rst", 34);
    check_pulse("after_rst", 32'd22, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
